// File: rtl/timer_pkg.sv
// Shared definitions for the DIV/TIMA/TMA/TAC timer: register addresses,
// FSM state encoding and the TAC clock-select decode.
package timer_pkg;

    localparam logic [15:0] ADDR_DIV  = 16'hFF04;
    localparam logic [15:0] ADDR_TIMA = 16'hFF05;
    localparam logic [15:0] ADDR_TMA  = 16'hFF06;
    localparam logic [15:0] ADDR_TAC  = 16'hFF07;

    typedef enum logic [1:0] {
        TimerIdle,
        TimerOverflow,
        TimerReload
    } timer_state_e;

    // Counter bit whose falling edge clocks TIMA for a given TAC[1:0].
    function automatic logic [3:0] tac_bit(input logic [1:0] clk_sel);
        logic [3:0] b;
        case (clk_sel)
            2'b00:   b = 4'd9;
            2'b01:   b = 4'd3;
            2'b10:   b = 4'd5;
            default: b = 4'd7;
        endcase
        return b;
    endfunction

endpackage

// File: rtl/timer_if.sv
// CPU system-bus port of the timer; the CPU side drives address/control/data,
// the timer returns read data and its address-hit flag.
interface timer_if;

    logic [1:0]  t_cycle;
    logic [15:0] mem_addr;
    logic        mem_enable;
    logic        mem_write;
    logic [7:0]  mem_data_in;
    logic [7:0]  mem_data_out;
    logic        mem_hit;

    modport master (
        output t_cycle, mem_addr, mem_enable, mem_write, mem_data_in,
        input  mem_data_out, mem_hit
    );

    modport slave (
        input  t_cycle, mem_addr, mem_enable, mem_write, mem_data_in,
        output mem_data_out, mem_hit
    );

endinterface

// File: rtl/timer.sv
// DIV/TIMA/TMA/TAC timer at 0xFF04-0xFF07 with a free-running 16-bit system
// counter, falling-edge tick detector and delayed TIMA reload / interrupt.
module timer
    import timer_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    timer_if.slave      bus,
    output logic        irq,
    output logic [15:0] sys_counter
);

    logic [15:0]  counter, counter_next;
    logic [7:0]   tima, tima_next;
    logic [7:0]   tma, tma_next;
    logic [2:0]   tac, tac_next;
    logic         sel_q, sel_next, tick;
    logic [1:0]   cnt, cnt_next;
    logic         irq_next;
    timer_state_e state, state_next;

    logic in_range, wr_commit;
    logic div_wr, tima_wr, tma_wr, tac_wr;

    assign in_range    = (bus.mem_addr[15:2] == ADDR_DIV[15:2]);
    assign bus.mem_hit = bus.mem_enable & in_range;
    assign wr_commit   = bus.mem_hit & bus.mem_write & (bus.t_cycle == 2'd3);
    assign div_wr      = wr_commit & (bus.mem_addr == ADDR_DIV);
    assign tima_wr     = wr_commit & (bus.mem_addr == ADDR_TIMA);
    assign tma_wr      = wr_commit & (bus.mem_addr == ADDR_TMA);
    assign tac_wr      = wr_commit & (bus.mem_addr == ADDR_TAC);

    assign sys_counter = counter;

    always_comb begin
        bus.mem_data_out = '1;
        if (bus.mem_hit) begin
            case (bus.mem_addr)
                ADDR_DIV:  bus.mem_data_out = counter[15:8];
                ADDR_TIMA: bus.mem_data_out = tima;
                ADDR_TMA:  bus.mem_data_out = tma;
                default:   bus.mem_data_out = {5'b11111, tac};
            endcase
        end
    end

    // Tick detection looks at the post-edge counter/TAC so DIV and TAC
    // writes that drop the selected bit produce a tick like a real fall.
    always_comb begin
        counter_next = div_wr ? '0 : counter + 16'd1;
        tac_next     = tac_wr ? bus.mem_data_in[2:0] : tac;
        sel_next     = tac_next[2] & counter_next[tac_bit(tac_next[1:0])];
        tick         = sel_q & ~sel_next;
    end

    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        tima_next  = tima;
        tma_next   = tma_wr ? bus.mem_data_in : tma;
        irq_next   = 1'b0;
        unique case (state)
            TimerIdle: begin
                if (tima_wr) begin
                    tima_next = bus.mem_data_in;
                end else if (tick) begin
                    if (tima == 8'hFF) begin
                        tima_next  = '0;
                        state_next = TimerOverflow;
                        cnt_next   = 2'd3;
                    end else begin
                        tima_next = tima + 8'd1;
                    end
                end
            end
            TimerOverflow: begin
                if (tima_wr) begin
                    tima_next  = bus.mem_data_in;
                    state_next = TimerIdle;
                end else if (cnt == 2'd0) begin
                    // tma_next already carries a same-edge TMA write
                    tima_next  = tma_next;
                    irq_next   = 1'b1;
                    state_next = TimerReload;
                    cnt_next   = 2'd3;
                end else begin
                    cnt_next = cnt - 2'd1;
                end
            end
            TimerReload: begin
                if (tma_wr) begin
                    tima_next = bus.mem_data_in;
                end
                if (cnt == 2'd0) begin
                    state_next = TimerIdle;
                end else begin
                    cnt_next = cnt - 2'd1;
                end
            end
            default: state_next = TimerIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            counter <= '0;
            tima    <= '0;
            tma     <= '0;
            tac     <= '0;
            sel_q   <= 1'b0;
            cnt     <= '0;
            irq     <= 1'b0;
            state   <= TimerIdle;
        end else begin
            counter <= counter_next;
            tima    <= tima_next;
            tma     <= tma_next;
            tac     <= tac_next;
            sel_q   <= sel_next;
            cnt     <= cnt_next;
            irq     <= irq_next;
            state   <= state_next;
        end
    end

endmodule

// File: doc/timer.md
# timer

Memory-mapped DIV/TIMA/TMA/TAC timer that responds to the CPU's system bus at 0xFF04–0xFF07 and raises the timer interrupt request. It sits on the CPU bus alongside other responders; the bus-level data mux selects its `mem_data_out` when `mem_hit` is high. A free-running 16-bit system counter runs at the core clock and is also exported for other blocks.

## Interface
No parameters.
- `clk`  in  1  core clock (4 MHz).
- `reset`  in  1  synchronous, active-high.
- `t_cycle`  in  2  CPU T-cycle phase; bus writes commit on the edge where `t_cycle == 3`.
- `mem_addr`  in  16  CPU bus address.
- `mem_enable`  in  1  CPU bus access enable.
- `mem_write`  in  1  CPU bus write enable.
- `mem_data_in`  in  8  write data from the CPU.
- `mem_data_out`  out  8  read data; combinational.
- `mem_hit`  out  1  combinational; high when `mem_enable` is set and the address is in 0xFF04–0xFF07.
- `irq`  out  1  one-clk timer interrupt pulse to the interrupt controller.
- `sys_counter`  out  16  internal counter value.

## Operation
- **Registers**
  - `counter[15:0]` increments every clk.
  - DIV (0xFF04) reads `counter[15:8]`; any write sets `counter` to 0.
  - TIMA (0xFF05) is the timer counter.
  - TMA (0xFF06) is the reload value.
  - TAC (0xFF07) reads `{5'b11111, tac[2:0]}`; writes store `mem_data_in[2:0]`.
- **Reads**
  - When `mem_hit` is high, `mem_data_out` returns the addressed register.
  - When `mem_hit` is low, `mem_data_out` is 0xFF.
- **Tick source**
  - `sel = tac[2] & counter[b]`, where b is 9, 3, 5, 7 for `tac[1:0]` = 00, 01, 10, 11.
  - `sel_q` is `sel` registered every clk.
  - A tick fires when `sel_q & !sel_next`. `sel_next` is computed from the post-edge counter and TAC, including DIV and TAC writes, so those writes can produce a spurious tick.
- **State machine: Idle, Overflow, Reload**
  - **Idle:** a tick with TIMA = 0xFF sets TIMA to 0x00 and moves to Overflow, with a 2-bit down-count of 3. Otherwise a tick does TIMA += 1 (8-bit wrap).
  - **Overflow:** lasts 4 clks and TIMA reads 0x00. When the count expires: TIMA ← TMA, `irq` goes high for 1 clk, and the state moves to Reload for 4 clks.
  - **Reload:** lasts 4 clks, then returns to Idle.
  - Ticks in Overflow and Reload are dropped.
- **Write precedence (same edge)**
  - DIV write beats counter increment.
  - TIMA write beats tick.
  - TIMA write in Overflow: TIMA takes the written value, state → Idle, no reload, no `irq`.
  - TIMA write in Reload: ignored.
  - TMA write in Reload: updates both TMA and TIMA.
  - TMA write on the reload edge itself: TIMA loads the new value.

## Timing
- **Reset values:** `counter` 0, TIMA 0, TMA 0, `tac` 0 (reads 0xF8), `sel_q` 0, state Idle, `irq` 0, `sys_counter` 0.
- **Idle-bus outputs:** `mem_data_out` 0xFF and `mem_hit` 0 whenever the bus is idle.
- **Reset mid-operation:** reset in any state returns to Idle with the values above. A pending reload and `irq` are discarded.
- **Read latency:** zero (combinational from the current register state).
- **Write latency:** the value is visible the clk after the commit edge.
- **Overflow sequence:** overflow on edge N → TIMA = TMA and `irq` = 1 during the cycle after edge N+4. Reload state covers edges N+5..N+8.
- **TIMA tick period (enabled):** 1024, 16, 64, 256 clks for `tac[1:0]` = 00, 01, 10, 11.

## Structure
- **Shared package:**
  - address constants `ADDR_DIV`, `ADDR_TIMA`, `ADDR_TMA`, `ADDR_TAC`;
  - `timer_state_e` (`TimerIdle`, `TimerOverflow`, `TimerReload`);
  - the TAC-to-bit select function.
- **Sub-modules:** none; a single module is natural. Bus decode, edge detector and FSM all fit in roughly 150–250 lines.

## Test plan
- **DIV count and clear:** after reset, run 1024 clks, read 0xFF04 → 0x04. Write 0xFF04 = 0xAB, read next M-cycle → 0x00.
- **Overflow and reload:** TAC = 0x05, TMA = 0x80, TIMA = 0xFE. Two ticks (32 clks) later TIMA reads 0x00 for exactly 4 clks, then reads 0x80. `irq` is high for exactly 1 clk.
- **Cancelled reload:** same setup, but write TIMA = 0x10 during the Overflow window → TIMA = 0x10, `irq` never asserted, TIMA not reloaded.
- **TMA write during Reload:** write TMA = 0x33 during Reload → TIMA reads 0x33. TIMA write 0x44 during Reload → TIMA stays 0x33.
- **DIV-write glitch tick:** TAC = 0x04, wait until `counter[9] = 1`, TIMA = 0x07, then write DIV → TIMA = 0x08 and `counter` = 0. Repeat with `counter[9] = 0` → TIMA stays 0x07.
- **Reset mid-Overflow and unmapped reads:** assert reset mid-Overflow → all registers 0, no `irq`. Read 0xFF08 → `mem_hit` = 0, `mem_data_out` = 0xFF. Read TAC after reset → 0xF8.
